// File: rtl/spi_conf_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_conf_rx_pkg
// Description : Command codes, FSM encoding and conf_word field positions
//               shared by the SPI configuration receiver and the mode logic.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_conf_rx_pkg;

  // Frame command field, taken from the top nibble of a 16-bit frame
  localparam logic [3:0] CMD_NOP         = 4'h0;
  localparam logic [3:0] CMD_SET_CONFREG = 4'h1;
  localparam logic [3:0] CMD_SET_DIVISOR = 4'h2;

  // conf_word field positions used by the major-mode muxes
  localparam int MAJOR_MODE_BIT = 5;
  localparam int MOD_TYPE_MSB   = 2;
  localparam int MOD_TYPE_LSB   = 0;

  // Receiver FSM
  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } rx_state_t;

endpackage : spi_conf_rx_pkg
`default_nettype wire

// File: rtl/spi_conf_rx_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchronizer for an asynchronous input, followed
//               by one delay flop and registered rise/fall pulses. The rise
//               and fall pulses are aligned with o_level (the delayed copy).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync_q;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Synchronizer chain, delay flop and single-cycle edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= w_sync_q;
      r_rise <= w_sync_q & ~r_dly;
      r_fall <= ~w_sync_q & r_dly;
    end
  end

  assign o_level = r_dly;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : sync_edge
`default_nettype wire

// File: rtl/spi_conf_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_conf_rx
// Description : SPI configuration receiver running entirely on ck_1356meg.
//               Captures 16-bit frames, commits conf_word/divisor only on a
//               validated frame at chip-select release, reads both back on
//               miso MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_conf_rx
  import spi_conf_rx_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BITS  = 16,
  parameter logic [7:0] CONF_RESET  = 8'h00,
  parameter logic [7:0] DIV_RESET   = 8'h00
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       spck,
  input  logic       ncs,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] conf_word,
  output logic [7:0] divisor,
  output logic       conf_stb,
  output logic       div_stb,
  output logic       frame_err
);

  localparam int              CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic                  w_spck_rise;
  logic                  w_spck_fall;
  logic                  w_spck_level;
  logic                  w_ncs_rise;
  logic                  w_ncs_fall;
  logic                  w_ncs_level;
  logic                  w_mosi;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [3:0]            w_cmd;

  logic [SYNC_STAGES:0]  r_mosi_sync;
  rx_state_t             r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [15:0]           r_tx;
  logic                  r_miso;
  logic [7:0]            r_conf;
  logic [7:0]            r_div;
  logic                  r_conf_stb;
  logic                  r_div_stb;
  logic                  r_frame_err;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_spck (
    .clk     (ck_1356meg),
    .rst     (reset),
    .i_d     (spck),
    .o_level (w_spck_level),
    .o_rise  (w_spck_rise),
    .o_fall  (w_spck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk     (ck_1356meg),
    .rst     (reset),
    .i_d     (ncs),
    .o_level (w_ncs_level),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  // mosi delayed by the same depth as the spck edge pulses so data and clock stay aligned
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], mosi};
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES];

  // Next shift/count values, so a chip-select release coinciding with the last
  // spck rise still commits the fully shifted frame
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    if (w_spck_rise) begin
      w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_mosi};
      if (r_cnt != C_CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_cmd = w_shift_nxt[FRAME_BITS-1 -: 4];

  // Receiver FSM: frame capture, readback shifting and validated commit
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_state     <= ST_DRAIN;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_conf      <= CONF_RESET;
      r_div       <= DIV_RESET;
      r_conf_stb  <= 1'b0;
      r_div_stb   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_conf_stb  <= 1'b0;
      r_div_stb   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_DRAIN: begin
          // a frame interrupted by reset must finish before we listen again
          if (w_ncs_level) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_ncs_fall) begin
            r_cnt   <= '0;
            r_tx    <= {r_conf, r_div};
            r_miso  <= r_conf[7];
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= w_cnt_nxt;
          if (w_spck_fall) begin
            r_tx   <= {r_tx[14:0], 1'b0};
            r_miso <= r_tx[14];
          end
          if (w_ncs_rise) begin
            r_miso  <= 1'b0;
            r_state <= ST_IDLE;
            if (w_cnt_nxt == C_CNT_FULL) begin
              case (w_cmd)
                CMD_SET_CONFREG: begin
                  r_conf     <= w_shift_nxt[7:0];
                  r_conf_stb <= 1'b1;
                end
                CMD_SET_DIVISOR: begin
                  r_div     <= w_shift_nxt[7:0];
                  r_div_stb <= 1'b1;
                end
                CMD_NOP: begin
                  r_frame_err <= 1'b0;
                end
                default: begin
                  r_frame_err <= 1'b1;
                end
              endcase
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_DRAIN;
        end
      endcase
    end
  end

  assign miso      = r_miso;
  assign conf_word = r_conf;
  assign divisor   = r_div;
  assign conf_stb  = r_conf_stb;
  assign div_stb   = r_div_stb;
  assign frame_err = r_frame_err;

  // spck level itself is not needed; only its edges drive the FSM
  logic w_unused;
  assign w_unused = w_spck_level;

endmodule : spi_conf_rx
`default_nettype wire

// File: tb/tb_spi_conf_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_conf_rx
// Description : Directed self-checking bench for spi_conf_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_conf_rx;

  localparam int HALF = 6;   // spck half period in system clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spck = 1'b0;
  logic       ncs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] conf_word;
  logic [7:0] divisor;
  logic       conf_stb;
  logic       div_stb;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_conf = 0;
  int n_div = 0;
  int n_ferr = 0;

  spi_conf_rx #(
    .SYNC_STAGES (2),
    .FRAME_BITS  (16),
    .CONF_RESET  (8'h00),
    .DIV_RESET   (8'h00)
  ) dut (
    .ck_1356meg (clk),
    .reset      (rst),
    .spck       (spck),
    .ncs        (ncs),
    .mosi       (mosi),
    .miso       (miso),
    .conf_word  (conf_word),
    .divisor    (divisor),
    .conf_stb   (conf_stb),
    .div_stb    (div_stb),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (conf_stb)  n_conf++;
    if (div_stb)   n_div++;
    if (frame_err) n_ferr++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // one spck period; miso is captured just before the rising edge
  task automatic clock_bit(input logic b, input bit close_now, output logic m);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m = miso;
    spck = 1'b1;
    if (close_now) ncs = 1'b1;
    repeat (HALF) @(negedge clk);
    spck = 1'b0;
  endtask

  // release chip select and report clocks until the first strobe/error (-1 if none)
  task automatic end_frame(output int lat);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (conf_stb || div_stb || frame_err)) lat = k;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [16:0] data, input int nbits,
                            output logic [15:0] rx, output int lat);
    logic m;
    rx = '0;
    start_frame();
    for (int i = 0; i < nbits; i++) begin
      clock_bit(data[nbits-1-i], 1'b0, m);
      rx = {rx[14:0], m};
    end
    end_frame(lat);
  endtask

  initial begin
    logic [15:0] rx;
    logic        m;
    int          lat;
    int          c0, d0, e0;
    logic [15:0] w;

    repeat (3) @(negedge clk);
    check("rst_conf", conf_word, 8'h00);
    check("rst_div", divisor, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_stb", {conf_stb, div_stb, frame_err}, 3'b000);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // frame 0x1025: conf write, latency SYNC_STAGES+2
    c0 = n_conf; d0 = n_div; e0 = n_ferr;
    send_frame(17'h01025, 16, rx, lat);
    check("f1025_lat", lat, 4);
    check("f1025_conf", conf_word, 8'h25);
    check("f1025_div", divisor, 8'h00);
    check("f1025_cstb", n_conf - c0, 1);
    check("f1025_err", n_ferr - e0, 0);

    // divisor then conf
    c0 = n_conf; d0 = n_div;
    send_frame(17'h0205F, 16, rx, lat);
    check("f205F_lat", lat, 4);
    check("f205F_div", divisor, 8'h5F);
    check("f205F_dstb", n_div - d0, 1);
    check("f205F_cstb", n_conf - c0, 0);
    c0 = n_conf; d0 = n_div;
    send_frame(17'h01003, 16, rx, lat);
    check("f1003_conf", conf_word, 8'h03);
    check("f1003_cstb", n_conf - c0, 1);
    check("f1003_dstb", n_div - d0, 0);

    // NOP readback
    c0 = n_conf; d0 = n_div; e0 = n_ferr;
    send_frame(17'h00000, 16, rx, lat);
    check("nop_miso", rx, 16'h035F);
    check("nop_lat", lat, -1);
    check("nop_pulses", (n_conf - c0) + (n_div - d0) + (n_ferr - e0), 0);
    check("nop_regs", {conf_word, divisor}, 16'h035F);

    // short and long frames carrying cmd 1
    c0 = n_conf; e0 = n_ferr;
    send_frame(17'h01077, 15, rx, lat);
    check("short_conf", conf_word, 8'h03);
    check("short_err", n_ferr - e0, 1);
    check("short_cstb", n_conf - c0, 0);
    c0 = n_conf; e0 = n_ferr;
    send_frame(17'h01077, 17, rx, lat);
    check("long_conf", conf_word, 8'h03);
    check("long_err", n_ferr - e0, 1);
    check("long_cstb", n_conf - c0, 0);

    // unknown command
    c0 = n_conf; d0 = n_div; e0 = n_ferr;
    send_frame(17'h07AAA, 16, rx, lat);
    check("unk_lat", lat, 4);
    check("unk_err", n_ferr - e0, 1);
    check("unk_regs", {conf_word, divisor}, 16'h035F);

    // reset in the middle of a frame
    w = 16'h10FF;
    start_frame();
    for (int i = 0; i < 8; i++) clock_bit(w[15-i], 1'b0, m);
    #2 rst = 1'b1;
    #1;
    check("arst_conf", conf_word, 8'h00);
    check("arst_div", divisor, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    c0 = n_conf; d0 = n_div; e0 = n_ferr;
    for (int i = 8; i < 16; i++) clock_bit(w[15-i], 1'b0, m);
    end_frame(lat);
    check("drain_lat", lat, -1);
    check("drain_pulses", (n_conf - c0) + (n_div - d0) + (n_ferr - e0), 0);
    check("drain_conf", conf_word, 8'h00);
    send_frame(17'h01011, 16, rx, lat);
    check("after_rst_conf", conf_word, 8'h11);

    // chip select released together with the 16th spck rise
    w = 16'h1042;
    c0 = n_conf; e0 = n_ferr;
    start_frame();
    for (int i = 0; i < 15; i++) clock_bit(w[15-i], 1'b0, m);
    clock_bit(w[0], 1'b1, m);
    repeat (12) @(negedge clk);
    check("simul_conf", conf_word, 8'h42);
    check("simul_cstb", n_conf - c0, 1);
    check("simul_err", n_ferr - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_conf_rx
`default_nettype wire
